cvxif_copro_responder: RTL and testbench
========================================

Name: cvxif_copro_responder

Overview:
- Coprocessor-side (responder) end of the CV-X-IF interface; the core is the issuer.
- Accepts custom-0 instructions from the core's issue port and buffers them until the core commits or kills them.
- Executes committed instructions in order and returns results through the result handshake.
- Serves as the in-tree reference coprocessor for CvxifEn=1 builds.

Parameters:
- XLEN, 32, operand/result width
- IdWidth, 4, issue/commit ID width
- NrEntries, 4, instruction buffer depth (power of 2, >=2)
- CustomOpcode, 7'b0001011, accepted major opcode

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  issue request ready
- issue_instr_i  in  32  instruction word
- issue_id_i  in  IdWidth  instruction ID
- issue_rs1_i  in  XLEN  rs1 operand
- issue_rs2_i  in  XLEN  rs2 operand
- issue_rs_valid_i  in  2  operand valid bits {rs2,rs1}
- issue_accept_o  out  1  instruction accepted (valid with issue handshake)
- issue_writeback_o  out  1  accepted instruction will write rd
- commit_valid_i  in  1  commit strobe
- commit_id_i  in  IdWidth  committed ID
- commit_kill_i  in  1  1 = discard instruction
- result_valid_o  out  1  result valid
- result_ready_i  in  1  result ready
- result_id_o  out  IdWidth  result ID
- result_rd_o  out  5  destination register
- result_data_o  out  XLEN  result value
- result_we_o  out  1  register write enable

Behaviour:
- Reset: all outputs 0; buffer empty; FSM IDLE. Reset mid-operation discards all entries and any in-flight multiply.
- Decode, combinational:
  - legal = opcode==CustomOpcode && funct7==0 && funct3 in {000 ADD, 001 XOR, 011 NOP, 010 MUL (macro only)}.
  - issue_accept_o = legal && issue_rs_valid_i==2'b11.
  - issue_writeback_o = issue_accept_o && funct3!=011 && rd!=0.
- Issue handshake:
  - issue_ready_o = !full, registered from occupancy. No same-cycle push-on-pop bypass when full.
  - Transfer when valid&&ready. An entry is allocated only if accept=1; rejected instructions consume one handshake and leave no state.
- Entry: {id, funct3, rd, we, rs1, rs2, committed, killed}, FIFO order.
- Commit:
  - commit_valid_i marks every valid entry whose id matches commit_id_i: committed=1, killed=commit_kill_i.
  - A commit in the same cycle as the push of that ID applies to the new entry.
  - Unmatched commits are ignored.
- Head FSM:
  - IDLE: if head valid && committed: go to DROP when killed. Otherwise go to EXEC for ADD/XOR/NOP, or MUL for MUL.
  - EXEC (1 cycle): compute rs1+rs2 or rs1^rs2 (mod 2^XLEN); NOP gives 0. Go to RESP.
  - MUL: start sub-module; wait for done (XLEN cycles); low XLEN bits of product; go to RESP.
  - RESP: result_valid_o=1 with registered id/rd/data/we, all held stable until result_ready_i. On handshake, pop head and go to IDLE.
  - DROP: pop head, no result, go to IDLE (1 cycle).
- Latency: commit to result_valid_o is 2 cycles for ALU ops and XLEN+2 cycles for MUL, when the entry is already at the head.
- Pointers wrap modulo NrEntries; full/empty resolved with an extra pointer bit.

Optional Feature:
- Macro: CVXIF_COPRO_MUL_EN.
- Defined: funct3=010 is legal; iterative shift-add multiplier instantiated; MUL state used.
- Undefined: funct3=010 is rejected (accept=0); no multiplier logic; MUL state absent.

Decomposition:
- Package cvxif_copro_pkg holds:
  - opcode/funct constants;
  - op_e enum;
  - entry_t struct;
  - state_e {IDLE, EXEC, MUL, RESP, DROP}.
- One sub-module: cvxif_copro_mul.
  - Iterative XLEN-cycle unsigned multiplier.
  - Ports: start_i, a_i, b_i, done_o, p_o.
  - Async active-high reset.

Test Plan:
- ADD, rs1=5, rs2=7, id=2, rd=10; commit id=2 kill=0 -> accept=1, wb=1; result id=2, rd=10, data=12, we=1, two cycles after commit.
- XOR id=1 then ADD id=2; commit id=1 kill=1, id=2 kill=0 -> no result for id=1; only id=2 result appears.
- Four accepted issues with no commit -> issue_ready_o=0. Then commit first and consume its result -> issue_ready_o=1 the cycle after pop.
- result_ready_i held low 5 cycles in RESP -> result_valid_o, id and data stable; pop only on handshake.
- Illegal cases -> accept=0, buffer occupancy unchanged:
  - opcode 0110011;
  - custom ADD with rs_valid=2'b01;
  - commit with an unknown ID.
- MUL 0xFFFFFFFF*3 with CVXIF_COPRO_MUL_EN defined -> data 0xFFFFFFFD after XLEN+2 cycles. Same instruction without the macro -> accept=0.

Source files
------------

// File: rtl/cvxif_copro_pkg.sv
// Shared types and constants for the CV-X-IF reference coprocessor.
// Optional feature macro: CVXIF_COPRO_MUL_EN (adds funct3=010 MUL and the S_MUL state).
package cvxif_copro_pkg;

  // Entry field widths; the top-level XLEN/IdWidth parameters default to these.
  localparam int unsigned CVXIF_XLEN = 32;
  localparam int unsigned CVXIF_ID_W = 4;

  localparam logic [6:0] CUSTOM0_OPCODE = 7'b0001011;
  localparam logic [6:0] FUNCT7_BASE    = 7'b0000000;

  // funct3 encodings of the custom-0 operations
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_XOR = 3'b001,
    OP_MUL = 3'b010,
    OP_NOP = 3'b011
  } op_e;

  // One buffered instruction, kept in FIFO order
  typedef struct packed {
    logic [CVXIF_ID_W-1:0] id;
    op_e                   op;
    logic [4:0]            rd;
    logic                  we;
    logic [CVXIF_XLEN-1:0] rs1;
    logic [CVXIF_XLEN-1:0] rs2;
    logic                  committed;
    logic                  killed;
  } entry_t;

  // Head-of-buffer execution FSM
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
`ifdef CVXIF_COPRO_MUL_EN
    S_MUL  = 3'd2,
`endif
    S_RESP = 3'd3,
    S_DROP = 3'd4
  } state_e;

  // funct3 values this build can execute
  function automatic logic op_legal(input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    case (funct3)
      OP_ADD, OP_XOR, OP_NOP: ok = 1'b1;
`ifdef CVXIF_COPRO_MUL_EN
      OP_MUL:                 ok = 1'b1;
`endif
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cvxif_copro_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// Loads on start_i, pulses done_o XLEN cycles later; p_o holds the low XLEN bits.
// Only instantiated when CVXIF_COPRO_MUL_EN is defined.
module cvxif_copro_mul #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] p_o
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d;

  // Next-state: load operands on start, else one shift-add step while busy
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      a_d    = a_i;
      b_d    = b_i;
      p_d    = '0;
      cnt_d  = CW'(XLEN);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (b_q[0]) p_d = p_q + a_q;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State registers; reset abandons any multiply in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign p_o    = p_q;

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF responder: accepts custom-0 instructions, buffers them until commit/kill,
// executes committed ones in order and returns results.
// Optional feature macro: CVXIF_COPRO_MUL_EN (iterative MUL on funct3=010).
// Handshakes: a transfer happens on a rising edge where valid && ready; the sender
// holds its payload stable while valid && !ready (result id/rd/data/we are held in RESP).
module cvxif_copro_responder
  import cvxif_copro_pkg::*;
#(
  parameter int unsigned XLEN         = CVXIF_XLEN,
  parameter int unsigned IdWidth      = CVXIF_ID_W,
  parameter int unsigned NrEntries    = 4,
  parameter logic [6:0]  CustomOpcode = CUSTOM0_OPCODE
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  input  logic [1:0]         issue_rs_valid_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic               result_we_o
);

  localparam int unsigned AW = $clog2(NrEntries);

  // Decode fields
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       legal;
  logic       unused_instr;

  assign opcode       = issue_instr_i[6:0];
  assign rd           = issue_instr_i[11:7];
  assign funct3       = issue_instr_i[14:12];
  assign funct7       = issue_instr_i[31:25];
  assign unused_instr = ^issue_instr_i[24:15];

  assign legal             = (opcode == CustomOpcode) && (funct7 == FUNCT7_BASE) && op_legal(funct3);
  assign issue_accept_o    = legal && (issue_rs_valid_i == 2'b11);
  assign issue_writeback_o = issue_accept_o && (funct3 != OP_NOP) && (rd != 5'd0);

  // Buffer and FSM state
  entry_t               mem_q [NrEntries];
  entry_t               mem_d [NrEntries];
  logic [NrEntries-1:0] valid_q, valid_d;
  logic [AW:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic                 ready_q, ready_d;
  state_e               state_q, state_d;
  logic                 res_valid_q, res_valid_d;
  logic [IdWidth-1:0]   res_id_q, res_id_d;
  logic [4:0]           res_rd_q, res_rd_d;
  logic [XLEN-1:0]      res_data_q, res_data_d;
  logic                 res_we_q, res_we_d;

  entry_t head;
  logic   head_valid, push, pop;

  assign head       = mem_q[rptr_q[AW-1:0]];
  assign head_valid = valid_q[rptr_q[AW-1:0]];
  assign push       = issue_valid_i && ready_q && issue_accept_o;

`ifdef CVXIF_COPRO_MUL_EN
  logic            mul_start, mul_done;
  logic [XLEN-1:0] mul_p;

  cvxif_copro_mul #(.XLEN(XLEN)) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (mul_start),
    .a_i     (head.rs1),
    .b_i     (head.rs2),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );
`endif

  // Buffer update (commit marking, push, pop) and head FSM next-state
  always_comb begin
    mem_d       = mem_q;
    valid_d     = valid_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    state_d     = state_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_rd_d    = res_rd_q;
    res_data_d  = res_data_q;
    res_we_d    = res_we_q;
    pop         = 1'b0;
`ifdef CVXIF_COPRO_MUL_EN
    mul_start   = 1'b0;
`endif

    // Commit marks every live entry carrying the ID; no match means no effect
    if (commit_valid_i) begin
      for (int i = 0; i < NrEntries; i++) begin
        if (valid_q[i] && (mem_q[i].id == commit_id_i)) begin
          mem_d[i].committed = 1'b1;
          mem_d[i].killed    = commit_kill_i;
        end
      end
    end

    // New entry also picks up a commit for its own ID in the same cycle
    if (push) begin
      mem_d[wptr_q[AW-1:0]].id        = issue_id_i;
      mem_d[wptr_q[AW-1:0]].op        = op_e'(funct3);
      mem_d[wptr_q[AW-1:0]].rd        = rd;
      mem_d[wptr_q[AW-1:0]].we        = issue_writeback_o;
      mem_d[wptr_q[AW-1:0]].rs1       = issue_rs1_i;
      mem_d[wptr_q[AW-1:0]].rs2       = issue_rs2_i;
      mem_d[wptr_q[AW-1:0]].committed = commit_valid_i && (commit_id_i == issue_id_i);
      mem_d[wptr_q[AW-1:0]].killed    = commit_valid_i && (commit_id_i == issue_id_i) && commit_kill_i;
      valid_d[wptr_q[AW-1:0]]         = 1'b1;
      wptr_d                          = wptr_q + (AW+1)'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (head_valid && head.committed) begin
          if (head.killed) begin
            state_d = S_DROP;
          end
`ifdef CVXIF_COPRO_MUL_EN
          else if (head.op == OP_MUL) begin
            state_d   = S_MUL;
            mul_start = 1'b1;
          end
`endif
          else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        res_valid_d = 1'b1;
        res_id_d    = head.id;
        res_rd_d    = head.rd;
        res_we_d    = head.we;
        case (head.op)
          OP_ADD:  res_data_d = head.rs1 + head.rs2;
          OP_XOR:  res_data_d = head.rs1 ^ head.rs2;
          default: res_data_d = '0;
        endcase
        state_d = S_RESP;
      end
`ifdef CVXIF_COPRO_MUL_EN
      S_MUL: begin
        if (mul_done) begin
          res_valid_d = 1'b1;
          res_id_d    = head.id;
          res_rd_d    = head.rd;
          res_we_d    = head.we;
          res_data_d  = mul_p;
          state_d     = S_RESP;
        end
      end
`endif
      S_RESP: begin
        if (result_ready_i) begin
          res_valid_d = 1'b0;
          pop         = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DROP: begin
        pop     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      valid_d[rptr_q[AW-1:0]] = 1'b0;
      rptr_d                  = rptr_q + (AW+1)'(1);
    end

    // Ready reflects next-cycle occupancy, so a pop re-opens issue one cycle later
    ready_d = !((wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]));
  end

  // Registers; reset empties the buffer and returns the FSM to IDLE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrEntries; i++) mem_q[i] <= '0;
      valid_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      ready_q     <= 1'b0;
      state_q     <= S_IDLE;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_rd_q    <= '0;
      res_data_q  <= '0;
      res_we_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NrEntries; i++) mem_q[i] <= mem_d[i];
      valid_q     <= valid_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ready_q     <= ready_d;
      state_q     <= state_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_rd_q    <= res_rd_d;
      res_data_q  <= res_data_d;
      res_we_q    <= res_we_d;
    end
  end

  assign issue_ready_o  = ready_q;
  assign result_valid_o = res_valid_q;
  assign result_id_o    = res_id_q;
  assign result_rd_o    = res_rd_q;
  assign result_data_o  = res_data_q;
  assign result_we_o    = res_we_q;

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Directed bench for cvxif_copro_responder: driver tasks push expected results
// into exp_q, a negedge monitor pops and compares on every result handshake.
module tb_cvxif_copro_responder;

  localparam int RW = 4 + 5 + 32 + 1;

  logic        clk, rst_i;
  logic        issue_valid_i, issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [3:0]  issue_id_i;
  logic [31:0] issue_rs1_i, issue_rs2_i;
  logic [1:0]  issue_rs_valid_i;
  logic        issue_accept_o, issue_writeback_o;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        result_valid_o, result_ready_i;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic [31:0] result_data_o;
  logic        result_we_o;

  logic [RW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  cvxif_copro_responder dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_instr_i     (issue_instr_i),
    .issue_id_i        (issue_id_i),
    .issue_rs1_i       (issue_rs1_i),
    .issue_rs2_i       (issue_rs2_i),
    .issue_rs_valid_i  (issue_rs_valid_i),
    .issue_accept_o    (issue_accept_o),
    .issue_writeback_o (issue_writeback_o),
    .commit_valid_i    (commit_valid_i),
    .commit_id_i       (commit_id_i),
    .commit_kill_i     (commit_kill_i),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .result_id_o       (result_id_o),
    .result_rd_o       (result_rd_o),
    .result_data_o     (result_data_o),
    .result_we_o       (result_we_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rdi, input logic [6:0] opc);
    return {f7, 5'd0, 5'd0, f3, rdi, opc};
  endfunction

  function automatic logic [RW-1:0] res(input logic [3:0] id, input logic [4:0] rdi,
                                        input logic [31:0] data, input logic we);
    return {id, rdi, data, we};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one issue request (caller sits just after a rising edge)
  task automatic issue(input string nm, input logic [31:0] instr, input logic [3:0] id,
                       input logic [31:0] a, input logic [31:0] b, input logic [1:0] rsv,
                       input logic exp_acc, input logic exp_wb);
    issue_valid_i    = 1'b1;
    issue_instr_i    = instr;
    issue_id_i       = id;
    issue_rs1_i      = a;
    issue_rs2_i      = b;
    issue_rs_valid_i = rsv;
    @(negedge clk);
    chk({nm, "_ready"}, 64'(issue_ready_o), 64'd1);
    chk({nm, "_accept"}, 64'(issue_accept_o), 64'(exp_acc));
    chk({nm, "_wb"}, 64'(issue_writeback_o), 64'(exp_wb));
    tick();
    issue_valid_i    = 1'b0;
    issue_rs_valid_i = 2'b00;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    tick();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  // Cycles from the last sampling edge until result_valid_o is seen
  task automatic check_latency(input string nm, input int exp_lat);
    int lat;
    lat = 0;
    @(negedge clk);
    while (!result_valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk(nm, 64'(lat), 64'(exp_lat));
    tick();
  endtask

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain pending=%0d required=0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: every result handshake must match the oldest expected result
  initial begin
    logic [RW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_i && result_valid_o && result_ready_i) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result got id=%0d data=%0h required=none", result_id_o, result_data_o);
        end else begin
          e = exp_q.pop_front();
          if ({result_id_o, result_rd_o, result_data_o, result_we_o} !== e) begin
            n_err++;
            $display("FAIL result got=%0h required=%0h",
                     {result_id_o, result_rd_o, result_data_o, result_we_o}, e);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst_i            = 1'b1;
    issue_valid_i    = 1'b0;
    issue_instr_i    = '0;
    issue_id_i       = '0;
    issue_rs1_i      = '0;
    issue_rs2_i      = '0;
    issue_rs_valid_i = 2'b00;
    commit_valid_i   = 1'b0;
    commit_id_i      = '0;
    commit_kill_i    = 1'b0;
    result_ready_i   = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(issue_ready_o), 64'd0);
    chk("rst_accept", 64'(issue_accept_o), 64'd0);
    chk("rst_valid", 64'(result_valid_o), 64'd0);
    chk("rst_out", 64'({result_id_o, result_rd_o, result_data_o, result_we_o}), 64'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // ADD 5+7, commit after issue, two-cycle latency
    issue("add1", mk(7'd0, 3'b000, 5'd10, 7'b0001011), 4'd2, 32'd5, 32'd7, 2'b11, 1'b1, 1'b1);
    exp_q.push_back(res(4'd2, 5'd10, 32'd12, 1'b1));
    commit(4'd2, 1'b0);
    check_latency("add1_lat", 2);
    wait_drain("add1");

    // XOR id1 killed, ADD id2 committed: only id2 returns
    issue("xor_k", mk(7'd0, 3'b001, 5'd3, 7'b0001011), 4'd1, 32'hF0, 32'h0F, 2'b11, 1'b1, 1'b1);
    issue("add2", mk(7'd0, 3'b000, 5'd4, 7'b0001011), 4'd2, 32'd100, 32'd23, 2'b11, 1'b1, 1'b1);
    commit(4'd1, 1'b1);
    exp_q.push_back(res(4'd2, 5'd4, 32'd123, 1'b1));
    commit(4'd2, 1'b0);
    wait_drain("kill");

    // Fill with four accepted entries, rejected ones interleaved must not allocate
    issue("add_rd0", mk(7'd0, 3'b000, 5'd0, 7'b0001011), 4'd3, 32'd10, 32'd20, 2'b11, 1'b1, 1'b0);
    issue("bad_opc", mk(7'd0, 3'b000, 5'd6, 7'b0110011), 4'd10, 32'd1, 32'd1, 2'b11, 1'b0, 1'b0);
    issue("nop", mk(7'd0, 3'b011, 5'd5, 7'b0001011), 4'd4, 32'd9, 32'd9, 2'b11, 1'b1, 1'b0);
    issue("bad_rsv", mk(7'd0, 3'b000, 5'd6, 7'b0001011), 4'd9, 32'd1, 32'd1, 2'b01, 1'b0, 1'b0);
    issue("bad_f7", mk(7'd1, 3'b000, 5'd6, 7'b0001011), 4'd11, 32'd1, 32'd1, 2'b11, 1'b0, 1'b0);
    commit(4'd12, 1'b0);
    issue("xor3", mk(7'd0, 3'b001, 5'd7, 7'b0001011), 4'd5, 32'hAAAA5555, 32'h0F0F0F0F, 2'b11, 1'b1, 1'b1);
    issue("add_wrap", mk(7'd0, 3'b000, 5'd8, 7'b0001011), 4'd6, 32'hFFFFFFFF, 32'd2, 2'b11, 1'b1, 1'b1);
    @(negedge clk);
    chk("full_ready", 64'(issue_ready_o), 64'd0);
    tick();
    exp_q.push_back(res(4'd3, 5'd0, 32'd30, 1'b0));
    commit(4'd3, 1'b0);
    begin
      int k;
      k = 0;
      @(negedge clk);
      while (!result_valid_o && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("full_lat", 64'(k), 64'd2);
      chk("full_ready_prepop", 64'(issue_ready_o), 64'd0);
      @(negedge clk);
      chk("ready_after_pop", 64'(issue_ready_o), 64'd1);
      tick();
    end
    exp_q.push_back(res(4'd4, 5'd5, 32'd0, 1'b0));
    commit(4'd4, 1'b0);
    exp_q.push_back(res(4'd5, 5'd7, 32'hA5A55A5A, 1'b1));
    commit(4'd5, 1'b0);
    exp_q.push_back(res(4'd6, 5'd8, 32'd1, 1'b1));
    commit(4'd6, 1'b0);
    wait_drain("fill");

    // Commit in the same cycle as the push; result held while ready is low
    result_ready_i = 1'b0;
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd7;
    commit_kill_i  = 1'b0;
    issue("add_hold", mk(7'd0, 3'b000, 5'd9, 7'b0001011), 4'd7, 32'h1234, 32'h1111, 2'b11, 1'b1, 1'b1);
    commit_valid_i = 1'b0;
    exp_q.push_back(res(4'd7, 5'd9, 32'h2345, 1'b1));
    check_latency("hold_lat", 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(result_valid_o), 64'd1);
      chk("hold_id", 64'(result_id_o), 64'd7);
      chk("hold_data", 64'(result_data_o), 64'h2345);
    end
    tick();
    result_ready_i = 1'b1;
    wait_drain("hold");

    // MUL 0xFFFFFFFF * 3
`ifdef CVXIF_COPRO_MUL_EN
    issue("mul", mk(7'd0, 3'b010, 5'd11, 7'b0001011), 4'd8, 32'hFFFFFFFF, 32'd3, 2'b11, 1'b1, 1'b1);
    exp_q.push_back(res(4'd8, 5'd11, 32'hFFFFFFFD, 1'b1));
    commit(4'd8, 1'b0);
    check_latency("mul_lat", 34);
    wait_drain("mul");
`else
    issue("mul_off", mk(7'd0, 3'b010, 5'd11, 7'b0001011), 4'd8, 32'hFFFFFFFF, 32'd3, 2'b11, 1'b0, 1'b0);
    commit(4'd8, 1'b0);
    wait_drain("mul_off");
`endif

    // Reset with an uncommitted entry buffered: it must be discarded
    issue("pre_rst", mk(7'd0, 3'b000, 5'd2, 7'b0001011), 4'd1, 32'd3, 32'd4, 2'b11, 1'b1, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(issue_ready_o), 64'd0);
    chk("midrst_valid", 64'(result_valid_o), 64'd0);
    tick();
    rst_i = 1'b0;
    tick();
    issue("post_rst", mk(7'd0, 3'b000, 5'd1, 7'b0001011), 4'd2, 32'd1, 32'd1, 2'b11, 1'b1, 1'b1);
    exp_q.push_back(res(4'd2, 5'd1, 32'd2, 1'b1));
    commit(4'd2, 1'b0);
    check_latency("post_rst_lat", 2);
    wait_drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
